// File: rtl/moxie_decode.sv
// Moxie decode stage: 16-bit instruction + 32-bit extension word -> registered micro-op and register controls.
// Latency: 1 cycle from opcode_i/operand_i to every output.
// Backpressure: stall_i=1 freezes all output registers and ignores the inputs; fetch holds its word meanwhile.
//
// Ports:
//   clk_i, rst_i              clock (rising edge), asynchronous active-high reset (clears outputs to NOP)
//   opcode_i, operand_i       instruction word and extension/immediate word from fetch
//   valid_i, stall_i          instruction qualifier, hazard stall (stall wins over valid)
//   op_o, operand_o           micro-op code and immediate for execute
//   regA_o, regB_o            register-file read indices
//   register_*_enable_o       read A / read B / write enables
//   register_write_index_o    destination register (the A field of a writing instruction)
//
// Build option: define MOXIE_DECODE_SHIFT_EN to decode 0x27/0x28/0x2d as LSHR/ASHL/ASHR;
// without it those opcodes decode as NOP.

module moxie_decode (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [15:0] opcode_i,
    input  logic [31:0] operand_i,
    input  logic        valid_i,
    input  logic        stall_i,
    output logic [5:0]  op_o,
    output logic [31:0] operand_o,
    output logic [3:0]  regA_o,
    output logic [3:0]  regB_o,
    output logic        register_A_read_enable_o,
    output logic        register_B_read_enable_o,
    output logic        register_write_enable_o,
    output logic [3:0]  register_write_index_o
);

    typedef enum logic [5:0] {
        UOP_NOP  = 6'd0,  UOP_MOV  = 6'd1,  UOP_LDI  = 6'd2,  UOP_ADD  = 6'd3,
        UOP_SUB  = 6'd4,  UOP_AND  = 6'd5,  UOP_OR   = 6'd6,  UOP_XOR  = 6'd7,
        UOP_NOT  = 6'd8,  UOP_NEG  = 6'd9,  UOP_INC  = 6'd10, UOP_DEC  = 6'd11,
        UOP_LSHR = 6'd12, UOP_ASHL = 6'd13, UOP_ASHR = 6'd14, UOP_MUL  = 6'd15
    } uop_e;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] operand;
        logic [3:0]  reg_a;
        logic [3:0]  reg_b;
        logic        rd_a_en;
        logic        rd_b_en;
        logic        wr_en;
        logic [3:0]  wr_idx;
    } dec_t;

    uop_e       uop;
    logic [3:0] fld_a;
    logic [3:0] fld_b;
    dec_t       dec_d;
    dec_t       dec_q;

    // Field extraction and micro-op selection. Invalid input, form 3 and
    // unmapped opcodes all fall through to NOP, which is also the bubble.
    always_comb begin
        uop   = UOP_NOP;
        fld_a = 4'd0;
        fld_b = 4'd0;
        if (valid_i) begin
            if (!opcode_i[15]) begin
                fld_a = opcode_i[7:4];
                fld_b = opcode_i[3:0];
                case (opcode_i[15:8])
                    8'h01:   uop = UOP_LDI;
                    8'h02:   uop = UOP_MOV;
                    8'h05:   uop = UOP_ADD;
                    8'h29:   uop = UOP_SUB;
                    8'h26:   uop = UOP_AND;
                    8'h2b:   uop = UOP_OR;
                    8'h2e:   uop = UOP_XOR;
                    8'h2c:   uop = UOP_NOT;
                    8'h2a:   uop = UOP_NEG;
                    8'h2f:   uop = UOP_MUL;
`ifdef MOXIE_DECODE_SHIFT_EN
                    8'h27:   uop = UOP_LSHR;
                    8'h28:   uop = UOP_ASHL;
                    8'h2d:   uop = UOP_ASHR;
`endif
                    default: uop = UOP_NOP;
                endcase
            end else if (!opcode_i[14]) begin
                fld_a = opcode_i[11:8];
                case (opcode_i[13:12])
                    2'b00:   uop = UOP_INC;
                    2'b01:   uop = UOP_DEC;
                    default: uop = UOP_NOP;   // gsr / ssr not handled here
                endcase
            end
        end
    end

    // Per-class enables and operand. Every non-NOP micro-op writes its A field.
    always_comb begin
        dec_d = '0;
        if (uop != UOP_NOP) begin
            dec_d.op     = uop;
            dec_d.reg_a  = fld_a;
            dec_d.wr_en  = 1'b1;
            dec_d.wr_idx = fld_a;
        end
        case (uop)
            UOP_NOP: ;
            UOP_LDI: begin
                dec_d.reg_b   = fld_b;
                dec_d.operand = operand_i;
            end
            UOP_MOV, UOP_NOT, UOP_NEG: begin
                dec_d.reg_b   = fld_b;
                dec_d.rd_b_en = 1'b1;
            end
            UOP_INC, UOP_DEC: begin
                // Immediate is the low byte of the instruction itself; B slot unused.
                dec_d.rd_a_en = 1'b1;
                dec_d.operand = {24'd0, opcode_i[7:0]};
            end
            default: begin
                dec_d.reg_b   = fld_b;
                dec_d.rd_a_en = 1'b1;
                dec_d.rd_b_en = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dec_q <= '0;
        end else if (!stall_i) begin
            dec_q <= dec_d;
        end
    end

    assign op_o                     = dec_q.op;
    assign operand_o                = dec_q.operand;
    assign regA_o                   = dec_q.reg_a;
    assign regB_o                   = dec_q.reg_b;
    assign register_A_read_enable_o = dec_q.rd_a_en;
    assign register_B_read_enable_o = dec_q.rd_b_en;
    assign register_write_enable_o  = dec_q.wr_en;
    assign register_write_index_o   = dec_q.wr_idx;

endmodule

// File: tb/tb_moxie_decode.sv
// Testbench for moxie_decode: directed cases plus randomized instructions,
// expected outputs queued at issue time and compared by an independent monitor.
module tb_moxie_decode;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] operand;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        rea;
        logic        reb;
        logic        we;
        logic [3:0]  wi;
    } out_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [15:0] opcode_i = '0;
    logic [31:0] operand_i = '0;
    logic        valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [5:0]  op_o;
    logic [31:0] operand_o;
    logic [3:0]  regA_o;
    logic [3:0]  regB_o;
    logic        register_A_read_enable_o;
    logic        register_B_read_enable_o;
    logic        register_write_enable_o;
    logic [3:0]  register_write_index_o;

    moxie_decode dut (
        .clk_i                    (clk_i),
        .rst_i                    (rst_i),
        .opcode_i                 (opcode_i),
        .operand_i                (operand_i),
        .valid_i                  (valid_i),
        .stall_i                  (stall_i),
        .op_o                     (op_o),
        .operand_o                (operand_o),
        .regA_o                   (regA_o),
        .regB_o                   (regB_o),
        .register_A_read_enable_o (register_A_read_enable_o),
        .register_B_read_enable_o (register_B_read_enable_o),
        .register_write_enable_o  (register_write_enable_o),
        .register_write_index_o   (register_write_index_o)
    );

    always #5 clk_i = ~clk_i;

    int   n_vec  = 0;
    int   n_fail = 0;
    out_t exp_q[$];
    out_t last_exp = '0;
    int   f1_map [int];
    logic [7:0] known [16] = '{8'h01, 8'h02, 8'h05, 8'h29, 8'h26, 8'h2b, 8'h2e, 8'h2c,
                               8'h2a, 8'h27, 8'h28, 8'h2d, 8'h2f, 8'h0f, 8'h00, 8'h7e};

    // Reference: table lookup for form 1, sub-op rule for form 2, then
    // operand/enable behaviour chosen by instruction class.
    function automatic out_t model(input logic [15:0] w, input logic [31:0] imm);
        out_t r;
        int u;
        logic [3:0] a, b;
        r = '0; u = 0; a = 4'd0; b = 4'd0;
        if (w[15] == 1'b0) begin
            a = w[7:4];
            b = w[3:0];
            if (f1_map.exists(int'(w[15:8]))) u = f1_map[int'(w[15:8])];
        end else if (w[14] == 1'b0) begin
            a = w[11:8];
            if (w[13:12] == 2'd0) u = 10;
            else if (w[13:12] == 2'd1) u = 11;
        end
        if (u == 0) return r;
        r.op = 6'(u);
        r.ra = a;
        r.we = 1'b1;
        r.wi = a;
        if (u == 10 || u == 11) begin
            r.rea     = 1'b1;
            r.operand = {24'd0, w[7:0]};
        end else if (u == 2) begin
            r.rb      = b;
            r.operand = imm;
        end else if (u == 1 || u == 8 || u == 9) begin
            r.rb  = b;
            r.reb = 1'b1;
        end else begin
            r.rb  = b;
            r.rea = 1'b1;
            r.reb = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input string name, input out_t e);
        out_t act;
        act = {op_o, operand_o, regA_o, regB_o, register_A_read_enable_o,
               register_B_read_enable_o, register_write_enable_o, register_write_index_o};
        n_vec++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got op=%0d opnd=%h A=%0d B=%0d rea=%b reb=%b we=%b wi=%0d, want op=%0d opnd=%h A=%0d B=%0d rea=%b reb=%b we=%b wi=%0d",
                     name, act.op, act.operand, act.ra, act.rb, act.rea, act.reb, act.we, act.wi,
                     e.op, e.operand, e.ra, e.rb, e.rea, e.reb, e.we, e.wi);
        end
    endtask

    task automatic apply(input logic [15:0] w, input logic [31:0] imm,
                         input logic v, input logic st);
        @(negedge clk_i);
        opcode_i  = w;
        operand_i = imm;
        valid_i   = v;
        stall_i   = st;
        if (!st) last_exp = v ? model(w, imm) : '0;
        exp_q.push_back(last_exp);
    endtask

    // Monitor: outputs are registered, so one expectation retires per edge.
    initial begin
        out_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pipe", e);
            end
        end
    end

    initial begin
        f1_map[8'h01] = 2;  f1_map[8'h02] = 1;  f1_map[8'h05] = 3;  f1_map[8'h29] = 4;
        f1_map[8'h26] = 5;  f1_map[8'h2b] = 6;  f1_map[8'h2e] = 7;  f1_map[8'h2c] = 8;
        f1_map[8'h2a] = 9;  f1_map[8'h2f] = 15;
`ifdef MOXIE_DECODE_SHIFT_EN
        f1_map[8'h27] = 12; f1_map[8'h28] = 13; f1_map[8'h2d] = 14;
`endif

        // Asynchronous reset before any clock edge.
        #3 rst_i = 1'b1;
        #1 check("rst_async", '0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        last_exp = '0;
        apply(16'h0523, 32'h0, 1'b0, 1'b0);   // bubble
        apply(16'h0000, 32'h0, 1'b0, 1'b0);

        // Directed decodes.
        apply(16'h0523, 32'h12345678, 1'b1, 1'b0);  // ADD
        apply(16'h0150, 32'hDEADBEEF, 1'b1, 1'b0);  // LDI
        apply(16'h8704, 32'hFFFFFFFF, 1'b1, 1'b0);  // INC
        apply(16'h9305, 32'h0, 1'b1, 1'b0);         // DEC
        apply(16'h0523, 32'h0, 1'b1, 1'b0);         // ADD then stall
        apply(16'h0261, 32'h0, 1'b1, 1'b1);
        apply(16'h0261, 32'h0, 1'b1, 1'b1);
        apply(16'h0261, 32'h0, 1'b1, 1'b0);         // MOV after release
        apply(16'h0000, 32'h0, 1'b1, 1'b0);
        apply(16'hC123, 32'h55, 1'b1, 1'b0);
        apply(16'h8A00, 32'h0, 1'b1, 1'b0);
        apply(16'hA123, 32'h0, 1'b1, 1'b0);         // gsr
        apply(16'hB123, 32'h0, 1'b1, 1'b0);         // ssr
        apply(16'h0F12, 32'h0, 1'b1, 1'b0);
        apply(16'h2712, 32'h0, 1'b1, 1'b0);
        apply(16'h2834, 32'h0, 1'b1, 1'b0);
        apply(16'h2D56, 32'h0, 1'b1, 1'b0);
        apply(16'h2C9A, 32'h0, 1'b1, 1'b0);         // NOT
        apply(16'h0523, 32'h0, 1'b1, 1'b1);         // stall holds previous

        // Reset asserted while stalled clears at once and stays clear.
        @(posedge clk_i);
        #2;
        stall_i = 1'b1;
        rst_i   = 1'b1;
        #1 check("rst_mid_stall", '0);
        last_exp = '0;
        repeat (2) @(posedge clk_i);
        #1 check("rst_held", '0);
        @(negedge clk_i);
        rst_i = 1'b0;
        apply(16'h0261, 32'h0, 1'b1, 1'b1);         // still stalled: zeros held
        apply(16'h0261, 32'h0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [15:0] w;
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0)      w = 16'($urandom);
            else if (sel == 1) w = {2'b10, 2'($urandom), 12'($urandom)};
            else               w = {known[$urandom_range(0, 15)], 8'($urandom)};
            apply(w, $urandom, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0));
        end

        @(negedge clk_i);
        stall_i = 1'b0;
        valid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
